bus_ctrl_rr: RTL and testbench

- Parametrised shared-bus controller for the SoC top level: NUM_M masters, 2**S_SEL_W slaves.
- Round-robin arbitration with registered grants.
- Muxes the owning master's address and control onto the shared slave bus, decodes chip-selects from the upper address bits, and returns the selected slave's read data and ready to all masters.
- Adds a bus-timeout watchdog that terminates hung accesses with an error response, an interrupt and a captured address.

---
 rtl/bus_ctrl_rr.sv | 198 +++++++++++++++++++
 tb/tb_bus_ctrl_rr.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_ctrl_rr.sv
// bus_ctrl_rr: shared-bus controller with round-robin arbitration and a bus-timeout watchdog.
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   m_req_          per-master request (active-low)
//   m_grnt_         per-master registered grant (active-low, one-hot-or-none)
//   m_addr          flattened master addresses, master i at [i*ADDR_W +: ADDR_W]
//   m_as_, m_rw     per-master address strobe (active-low) and direction (1=read)
//   m_wr_data       flattened master write data
//   m_rd_data       read data returned to all masters
//   m_rdy_          shared ready (active-low)
//   m_err           high in the cycle of a timeout-terminated access
//   s_addr, s_as_, s_rw, s_wr_data   owner's signals driven onto the slave bus
//   s_cs_           decoded chip-selects (active-low)
//   s_rd_data       flattened slave read data
//   s_rdy_          per-slave ready (active-low)
//   err_irq         one-cycle pulse after a timeout
//   err_addr        address of the last timed-out access
//   err_cnt         saturating timeout count
module bus_ctrl_rr #(
    parameter int unsigned NUM_M       = 4,
    parameter int unsigned S_SEL_W     = 3,
    parameter int unsigned ADDR_W      = 30,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_M-1:0]              m_req_,
    output logic [NUM_M-1:0]              m_grnt_,
    input  logic [NUM_M*ADDR_W-1:0]       m_addr,
    input  logic [NUM_M-1:0]              m_as_,
    input  logic [NUM_M-1:0]              m_rw,
    input  logic [NUM_M*DATA_W-1:0]       m_wr_data,
    output logic [DATA_W-1:0]             m_rd_data,
    output logic                          m_rdy_,
    output logic                          m_err,
    output logic [ADDR_W-1:0]             s_addr,
    output logic                          s_as_,
    output logic                          s_rw,
    output logic [DATA_W-1:0]             s_wr_data,
    output logic [2**S_SEL_W-1:0]         s_cs_,
    input  logic [(2**S_SEL_W)*DATA_W-1:0] s_rd_data,
    input  logic [2**S_SEL_W-1:0]         s_rdy_,
    output logic                          err_irq,
    output logic [ADDR_W-1:0]             err_addr,
    output logic [7:0]                    err_cnt
);

    localparam int unsigned NUM_S = 2**S_SEL_W;
    localparam int unsigned MW    = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    typedef enum logic {IDLE, OWNED} state_e;

    state_e             state_q;
    logic [MW-1:0]      owner_q;
    logic [MW-1:0]      rr_ptr_q;
    logic [NUM_M-1:0]   m_grnt_q;
    logic [15:0]        wait_cnt_q;
    logic               err_irq_q;
    logic [ADDR_W-1:0]  err_addr_q;
    logic [7:0]         err_cnt_q;

    logic [ADDR_W-1:0]  m_addr_a    [NUM_M];
    logic [DATA_W-1:0]  m_wr_data_a [NUM_M];
    logic [DATA_W-1:0]  s_rd_data_a [NUM_S];

    logic               any_req;
    logic               found;
    logic [MW-1:0]      cand_idx;
    logic [MW-1:0]      winner;
    logic [NUM_M-1:0]   grant_d;
    logic               owner_rel;
    logic               owned;
    logic [S_SEL_W-1:0] sel;
    logic               slv_rdy_;
    logic [DATA_W-1:0]  slv_data;
    logic               pending;
    logic               err_cycle;

    always_comb begin
        for (int unsigned i = 0; i < NUM_M; i++) begin
            m_addr_a[i]    = m_addr[i*ADDR_W +: ADDR_W];
            m_wr_data_a[i] = m_wr_data[i*DATA_W +: DATA_W];
        end
        for (int unsigned k = 0; k < NUM_S; k++) begin
            s_rd_data_a[k] = s_rd_data[k*DATA_W +: DATA_W];
        end
    end

    // Scan from rr_ptr+1 round to rr_ptr. In OWNED, rr_ptr equals the owner,
    // so this also yields "next requester after the owner" on a handover.
    always_comb begin
        any_req  = ~&m_req_;
        found    = 1'b0;
        winner   = rr_ptr_q;
        cand_idx = '0;
        for (int unsigned i = 1; i <= NUM_M; i++) begin
            cand_idx = MW'((32'(rr_ptr_q) + i) % NUM_M);
            if (!found && !m_req_[cand_idx]) begin
                found  = 1'b1;
                winner = cand_idx;
            end
        end
        grant_d         = '1;
        grant_d[winner] = 1'b0;
    end

    assign owner_rel = (state_q == OWNED) && m_req_[owner_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= MW'(NUM_M - 1);
            m_grnt_q <= '1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q  <= OWNED;
                        owner_q  <= winner;
                        rr_ptr_q <= winner;
                        m_grnt_q <= grant_d;
                    end
                end
                OWNED: begin
                    if (m_req_[owner_q]) begin
                        if (any_req) begin
                            owner_q  <= winner;
                            rr_ptr_q <= winner;
                            m_grnt_q <= grant_d;
                        end else begin
                            state_q  <= IDLE;
                            m_grnt_q <= '1;
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    m_grnt_q <= '1;
                end
            endcase
        end
    end

    always_comb begin
        owned     = (state_q == OWNED);
        s_addr    = owned ? m_addr_a[owner_q]    : '0;
        s_as_     = owned ? m_as_[owner_q]       : 1'b1;
        s_rw      = owned ? m_rw[owner_q]        : 1'b1;
        s_wr_data = owned ? m_wr_data_a[owner_q] : '0;
    end

    always_comb begin
        sel       = s_addr[ADDR_W-1 -: S_SEL_W];
        slv_rdy_  = s_rdy_[sel];
        slv_data  = s_rd_data_a[sel];
        s_cs_     = '1;
        if (!s_as_) begin
            s_cs_[sel] = 1'b0;
        end
        pending   = !s_as_ && slv_rdy_;
        // A slave ready in the limit cycle keeps pending low, so it wins.
        err_cycle = (TIMEOUT_CYC != 0) && pending && (wait_cnt_q == 16'(TIMEOUT_CYC));
        m_err     = err_cycle;
        m_rdy_    = s_as_ ? 1'b1 : (err_cycle ? 1'b0 : slv_rdy_);
        m_rd_data = (s_as_ || err_cycle) ? '0 : slv_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
            err_irq_q  <= 1'b0;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            if (TIMEOUT_CYC == 0 || owner_rel || err_cycle || !pending) begin
                wait_cnt_q <= '0;
            end else begin
                wait_cnt_q <= wait_cnt_q + 16'd1;
            end
            err_irq_q <= err_cycle;
            if (err_cycle) begin
                err_addr_q <= s_addr;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_q <= err_cnt_q + 8'd1;
                end
            end
        end
    end

    assign m_grnt_  = m_grnt_q;
    assign err_irq  = err_irq_q;
    assign err_addr = err_addr_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_bus_ctrl_rr.sv
// tb_bus_ctrl_rr: directed bench for bus_ctrl_rr. One instance uses a
// 4-cycle timeout, a second shares its inputs with the watchdog disabled.
module tb_bus_ctrl_rr;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   m_req_, m_as_, m_rw;
    logic [119:0] m_addr;
    logic [127:0] m_wr_data;
    logic [255:0] s_rd_data;
    logic [7:0]   s_rdy_;

    logic [3:0]   m_grnt_;
    logic [31:0]  m_rd_data;
    logic         m_rdy_, m_err;
    logic [29:0]  s_addr;
    logic         s_as_, s_rw;
    logic [31:0]  s_wr_data;
    logic [7:0]   s_cs_;
    logic         err_irq;
    logic [29:0]  err_addr;
    logic [7:0]   err_cnt;

    logic [3:0]   z_grnt_;
    logic [31:0]  z_rd_data;
    logic         z_rdy_, z_err;
    logic [29:0]  z_s_addr;
    logic         z_s_as_, z_s_rw;
    logic [31:0]  z_s_wr_data;
    logic [7:0]   z_s_cs_;
    logic         z_err_irq;
    logic [29:0]  z_err_addr;
    logic [7:0]   z_err_cnt;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bus_ctrl_rr #(.NUM_M(4), .S_SEL_W(3), .ADDR_W(30), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .reset(reset), .m_req_(m_req_), .m_grnt_(m_grnt_), .m_addr(m_addr),
        .m_as_(m_as_), .m_rw(m_rw), .m_wr_data(m_wr_data), .m_rd_data(m_rd_data),
        .m_rdy_(m_rdy_), .m_err(m_err), .s_addr(s_addr), .s_as_(s_as_), .s_rw(s_rw),
        .s_wr_data(s_wr_data), .s_cs_(s_cs_), .s_rd_data(s_rd_data), .s_rdy_(s_rdy_),
        .err_irq(err_irq), .err_addr(err_addr), .err_cnt(err_cnt)
    );

    bus_ctrl_rr #(.NUM_M(4), .S_SEL_W(3), .ADDR_W(30), .DATA_W(32), .TIMEOUT_CYC(0)) dut0 (
        .clk(clk), .reset(reset), .m_req_(m_req_), .m_grnt_(z_grnt_), .m_addr(m_addr),
        .m_as_(m_as_), .m_rw(m_rw), .m_wr_data(m_wr_data), .m_rd_data(z_rd_data),
        .m_rdy_(z_rdy_), .m_err(z_err), .s_addr(z_s_addr), .s_as_(z_s_as_), .s_rw(z_s_rw),
        .s_wr_data(z_s_wr_data), .s_cs_(z_s_cs_), .s_rd_data(s_rd_data), .s_rdy_(s_rdy_),
        .err_irq(z_err_irq), .err_addr(z_err_addr), .err_cnt(z_err_cnt)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  grnt;
        logic [7:0]  cs;
        logic        rdy;
        logic [31:0] rd;
    } vec_t;

    vec_t vt [26];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Masters strobe whenever they request.
    task automatic drive(input logic [3:0] req, input logic [7:0] rdy);
        m_req_ = req;
        m_as_  = req;
        s_rdy_ = rdy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // slave k returns CAFE_0001+k; master addresses select slaves 0,5,2,7
        m_addr    = {30'h3800_0000, 30'h1000_0000, 30'h2800_0000, 30'h0000_0010};
        m_wr_data = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        m_rw      = 4'hF;
        for (int k = 0; k < 8; k++) s_rd_data[k*32 +: 32] = 32'hCAFE_0001 + k;
        drive(4'hF, 8'h00);
        reset = 1'b1;

        //        rst   req   grnt  cs     rdy   rd
        vt[0]  = '{1'b0, 4'hE, 4'hF, 8'hFF, 1'b1, 32'h0};
        vt[1]  = '{1'b0, 4'hE, 4'hE, 8'hFE, 1'b0, 32'hCAFE_0001};
        vt[2]  = '{1'b0, 4'hF, 4'hE, 8'hFF, 1'b1, 32'h0};
        vt[3]  = '{1'b0, 4'hF, 4'hF, 8'hFF, 1'b1, 32'h0};
        vt[4]  = '{1'b1, 4'hF, 4'hF, 8'hFF, 1'b1, 32'h0};
        vt[5]  = '{1'b0, 4'hA, 4'hF, 8'hFF, 1'b1, 32'h0};
        vt[6]  = '{1'b0, 4'hA, 4'hE, 8'hFE, 1'b0, 32'hCAFE_0001};
        vt[7]  = '{1'b0, 4'hB, 4'hE, 8'hFF, 1'b1, 32'h0};
        vt[8]  = '{1'b0, 4'hA, 4'hB, 8'hFB, 1'b0, 32'hCAFE_0003};
        vt[9]  = '{1'b0, 4'hA, 4'hB, 8'hFB, 1'b0, 32'hCAFE_0003};
        vt[10] = '{1'b0, 4'hE, 4'hB, 8'hFF, 1'b1, 32'h0};
        vt[11] = '{1'b0, 4'hE, 4'hE, 8'hFE, 1'b0, 32'hCAFE_0001};
        vt[12] = '{1'b0, 4'hF, 4'hE, 8'hFF, 1'b1, 32'h0};
        vt[13] = '{1'b1, 4'hF, 4'hF, 8'hFF, 1'b1, 32'h0};
        vt[14] = '{1'b0, 4'h0, 4'hF, 8'hFF, 1'b1, 32'h0};
        vt[15] = '{1'b0, 4'h0, 4'hE, 8'hFE, 1'b0, 32'hCAFE_0001};
        vt[16] = '{1'b0, 4'h1, 4'hE, 8'hFF, 1'b1, 32'h0};
        vt[17] = '{1'b0, 4'h1, 4'hD, 8'hDF, 1'b0, 32'hCAFE_0006};
        vt[18] = '{1'b0, 4'h3, 4'hD, 8'hFF, 1'b1, 32'h0};
        vt[19] = '{1'b0, 4'h3, 4'hB, 8'hFB, 1'b0, 32'hCAFE_0003};
        vt[20] = '{1'b0, 4'h7, 4'hB, 8'hFF, 1'b1, 32'h0};
        vt[21] = '{1'b0, 4'h7, 4'h7, 8'h7F, 1'b0, 32'hCAFE_0008};
        vt[22] = '{1'b0, 4'hE, 4'h7, 8'hFF, 1'b1, 32'h0};
        vt[23] = '{1'b0, 4'hE, 4'hE, 8'hFE, 1'b0, 32'hCAFE_0001};
        vt[24] = '{1'b0, 4'hF, 4'hE, 8'hFF, 1'b1, 32'h0};
        vt[25] = '{1'b0, 4'hF, 4'hF, 8'hFF, 1'b1, 32'h0};

        next_cycle();
        next_cycle();
        check("reset_grnt", 64'(m_grnt_), 64'h F);
        check("reset_bus", 64'({s_as_, s_rw, s_cs_, s_wr_data}), 64'({1'b1, 1'b1, 8'hFF, 32'h0}));
        check("reset_resp", 64'({m_rdy_, m_err, m_rd_data}), 64'({1'b1, 1'b0, 32'h0}));
        check("reset_err", 64'({err_irq, err_addr, err_cnt}), 64'h0);

        // Table: m0 read, m0/m2 contention with handover, four-way rotation.
        for (int i = 0; i < 26; i++) begin
            if (i != 0) next_cycle();
            reset = vt[i].rst;
            drive(vt[i].req, 8'h00);
            #2;
            check($sformatf("vec%0d", i),
                  64'({m_grnt_, s_cs_, m_rdy_, m_err, m_rd_data}),
                  64'({vt[i].grnt, vt[i].cs, vt[i].rdy, 1'b0, vt[i].rd}));
        end

        // Timeout: m1 to hung slave 5.
        next_cycle(); reset = 1'b1; drive(4'hF, 8'hFF);
        next_cycle(); reset = 1'b0; drive(4'hD, 8'hFF);
        for (int c = 1; c <= 12; c++) begin
            next_cycle();
            #2;
            if (c == 1) check("to_grnt", 64'({m_grnt_, s_cs_}), 64'({4'hD, 8'hDF}));
            if (c < 5) check($sformatf("to_wait%0d", c), 64'({m_rdy_, m_err}), 64'({1'b1, 1'b0}));
            if (c == 5) check("to_errcyc", 64'({m_rdy_, m_err, m_rd_data, err_irq}),
                              64'({1'b0, 1'b1, 32'h0, 1'b0}));
            if (c == 6) check("to_irq", 64'({err_irq, err_addr, err_cnt}),
                              64'({1'b1, 30'h2800_0000, 8'd1}));
            if (c == 7) check("to_irq_end", 64'(err_irq), 64'h0);
            check($sformatf("nowd%0d", c), 64'({z_rdy_, z_err, z_err_irq, z_err_cnt}),
                  64'({1'b1, 1'b0, 1'b0, 8'd0}));
        end
        next_cycle(); drive(4'hF, 8'hFF);

        // Slave ready arrives in the limit cycle.
        next_cycle(); reset = 1'b1;
        next_cycle(); reset = 1'b0; drive(4'hD, 8'hFF);
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            if (c == 5) s_rdy_ = 8'hDF;
            if (c == 6) drive(4'hF, 8'hFF);
            #2;
            if (c == 4) check("race_wait", 64'({m_rdy_, m_err}), 64'({1'b1, 1'b0}));
            if (c == 5) check("race_resp", 64'({m_rdy_, m_err, m_rd_data}),
                              64'({1'b0, 1'b0, 32'hCAFE_0006}));
            if (c == 6) check("race_noerr", 64'({err_irq, err_cnt}), 64'h0);
        end

        // Reset in the middle of an m3 access, after it has timed out once.
        next_cycle(); reset = 1'b1; drive(4'hF, 8'hFF);
        next_cycle(); reset = 1'b0; drive(4'h7, 8'hFF);
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            #2;
            if (c == 1) check("m3_grnt", 64'({m_grnt_, s_cs_}), 64'({4'h7, 8'h7F}));
            if (c == 5) check("m3_err", 64'(m_err), 64'h1);
            if (c == 6) check("m3_errcnt", 64'({err_irq, err_addr, err_cnt}),
                              64'({1'b1, 30'h3800_0000, 8'd1}));
        end
        next_cycle(); reset = 1'b1;
        next_cycle(); reset = 1'b0; drive(4'h6, 8'h00);
        #2;
        check("mid_rst_bus", 64'({m_grnt_, s_as_, s_cs_, m_err}), 64'({4'hF, 1'b1, 8'hFF, 1'b0}));
        check("mid_rst_err", 64'({err_irq, err_addr, err_cnt}), 64'h0);
        next_cycle();
        #2;
        check("post_rst_m0", 64'({m_grnt_, m_rd_data}), 64'({4'hE, 32'hCAFE_0001}));
        next_cycle(); drive(4'hF, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
